// File: rtl/controle_preparo.sv
// rtl/controle_preparo.sv - drink-preparation sequencer downstream of the payment FSM
// Runs the timed cup/coffee/milk/foam stages on a new paid code, pulses refund on a new incorrect code.
module controle_preparo #(
  parameter int T_COPO   = 2,
  parameter int T_CAFE   = 4,
  parameter int T_LEITE  = 3,
  parameter int T_ESPUMA = 2,
  parameter int T_DEVOL  = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] SAIDA,
  input  logic [1:0] PRODUTO,
  input  logic       RETIRADA,
  output logic [3:0] VALVULA,
  output logic       DEVOLVE,
  output logic       PRONTO,
  output logic       OCUPADO,
  output logic [2:0] ESTADO_DISPLAY
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'b000,
    COPO      = 3'b001,
    CAFE      = 3'b010,
    LEITE     = 3'b011,
    ESPUMA    = 3'b100,
    ESPERA    = 3'b101,
    DEVOLUCAO = 3'b110
  } estado_t;

  estado_t    r_estado;
  estado_t    w_prox;
  logic [7:0] r_cont;
  logic [7:0] w_carga;
  logic [1:0] r_prod;
  logic [1:0] r_saida_ant;
  logic       w_novo_pago;
  logic       w_novo_erro;
  logic       w_fim;

  // Payment codes are held level, so only their first cycle counts.
  assign w_novo_pago = (SAIDA == 2'b11) && (r_saida_ant != 2'b11);
  assign w_novo_erro = (SAIDA == 2'b10) && (r_saida_ant != 2'b10);
  assign w_fim       = (r_cont == 8'd0);

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO: begin
        if (w_novo_pago) begin
          if (PRODUTO == 2'b10) w_prox = DEVOLUCAO;
          else                  w_prox = COPO;
        end else if (w_novo_erro) begin
          w_prox = DEVOLUCAO;
        end
      end
      COPO:      if (w_fim) w_prox = CAFE;
      CAFE: begin
        if (w_fim) begin
          if (r_prod == 2'b01 || r_prod == 2'b11) w_prox = LEITE;
          else                                    w_prox = ESPERA;
        end
      end
      LEITE: begin
        if (w_fim) begin
          if (r_prod == 2'b11) w_prox = ESPUMA;
          else                 w_prox = ESPERA;
        end
      end
      ESPUMA:    if (w_fim) w_prox = ESPERA;
      ESPERA:    if (RETIRADA) w_prox = OCIOSO;
      DEVOLUCAO: if (w_fim) w_prox = OCIOSO;
      default:   w_prox = OCIOSO;
    endcase
  end

  // Counter preload for the state being entered; untimed states load zero.
  always_comb begin
    w_carga = 8'd0;
    case (w_prox)
      COPO:      w_carga = 8'(T_COPO - 1);
      CAFE:      w_carga = 8'(T_CAFE - 1);
      LEITE:     w_carga = 8'(T_LEITE - 1);
      ESPUMA:    w_carga = 8'(T_ESPUMA - 1);
      DEVOLUCAO: w_carga = 8'(T_DEVOL - 1);
      default:   w_carga = 8'd0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_estado    <= OCIOSO;
      r_cont      <= 8'd0;
      r_prod      <= 2'b00;
      r_saida_ant <= 2'b00;
    end else begin
      r_saida_ant <= SAIDA;
      r_estado    <= w_prox;
      if (w_prox != r_estado) r_cont <= w_carga;
      else if (r_cont != 8'd0) r_cont <= r_cont - 8'd1;
      if (r_estado == OCIOSO && w_novo_pago && PRODUTO != 2'b10) r_prod <= PRODUTO;
    end
  end

  always_comb begin
    VALVULA        = 4'b0000;
    DEVOLVE        = 1'b0;
    PRONTO         = 1'b0;
    OCUPADO        = (r_estado != OCIOSO);
    ESTADO_DISPLAY = r_estado;
    case (r_estado)
      COPO:      VALVULA = 4'b0001;
      CAFE:      VALVULA = 4'b0010;
      LEITE:     VALVULA = 4'b0100;
      ESPUMA:    VALVULA = 4'b1000;
      ESPERA:    PRONTO  = 1'b1;
      DEVOLUCAO: DEVOLVE = 1'b1;
      default:   VALVULA = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_controle_preparo.sv
// tb/tb_controle_preparo.sv - scoreboard bench for controle_preparo
// Expected output words are queued as stimulus is driven and popped one per clock.
module tb_controle_preparo;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] SAIDA;
  logic [1:0] PRODUTO;
  logic       RETIRADA;
  logic [3:0] VALVULA;
  logic       DEVOLVE;
  logic       PRONTO;
  logic       OCUPADO;
  logic [2:0] ESTADO_DISPLAY;

  int n_vec = 0;
  int n_err = 0;
  string tag_cur = "init";
  logic [9:0] sb_q[$];

  localparam logic [2:0] S_OCI = 3'b000, S_COP = 3'b001, S_CAF = 3'b010, S_LEI = 3'b011,
                         S_ESP = 3'b100, S_WAI = 3'b101, S_DEV = 3'b110;

  controle_preparo dut (
    .CLK(CLK), .RESET(RESET), .SAIDA(SAIDA), .PRODUTO(PRODUTO), .RETIRADA(RETIRADA),
    .VALVULA(VALVULA), .DEVOLVE(DEVOLVE), .PRONTO(PRONTO), .OCUPADO(OCUPADO),
    .ESTADO_DISPLAY(ESTADO_DISPLAY)
  );

  always #5 CLK = ~CLK;

  // {VALVULA, DEVOLVE, PRONTO, OCUPADO, ESTADO_DISPLAY}
  function automatic logic [9:0] exp_word(input logic [2:0] st);
    logic [3:0] v;
    v = (st == S_COP) ? 4'b0001 : (st == S_CAF) ? 4'b0010 :
        (st == S_LEI) ? 4'b0100 : (st == S_ESP) ? 4'b1000 : 4'b0000;
    return {v, st == S_DEV, st == S_WAI, st != S_OCI, st};
  endfunction

  function automatic logic [9:0] obs_word();
    return {VALVULA, DEVOLVE, PRONTO, OCUPADO, ESTADO_DISPLAY};
  endfunction

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(exp_word(st));
  endtask

  task automatic tick();
    logic [9:0] e;
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag_cur, "_empty"}, obs_word(), 10'h3ff);
    end else begin
      e = sb_q.pop_front();
      chk(tag_cur, obs_word(), e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sb_q.size() != 0; i++) tick();
    if (sb_q.size() != 0) begin
      chk({tag_cur, "_drain"}, 10'(sb_q.size()), 10'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    RESET = 1'b1; SAIDA = 2'b00; PRODUTO = 2'b00; RETIRADA = 1'b0;
    #2;
    tag_cur = "reset";
    chk(tag_cur, obs_word(), exp_word(S_OCI));
    @(posedge CLK); #1;
    RESET = 1'b0;

    tag_cur = "collect";
    SAIDA = 2'b01;
    push(S_OCI, 1); drain();

    tag_cur = "coffee";
    SAIDA = 2'b11; PRODUTO = 2'b00;
    push(S_COP, 2); push(S_CAF, 4); push(S_WAI, 3); drain();
    RETIRADA = 1'b1;
    tag_cur = "coffee_pick";
    push(S_OCI, 2); drain();
    RETIRADA = 1'b0;

    tag_cur = "capp";
    SAIDA = 2'b00;
    push(S_OCI, 1); drain();
    SAIDA = 2'b11; PRODUTO = 2'b11;
    push(S_COP, 2); drain();
    PRODUTO = 2'b00;
    push(S_CAF, 4); push(S_LEI, 3); push(S_ESP, 2); push(S_WAI, 2); drain();
    RETIRADA = 1'b1;
    push(S_OCI, 1); drain();
    RETIRADA = 1'b0;

    tag_cur = "refund";
    SAIDA = 2'b00;
    push(S_OCI, 1); drain();
    SAIDA = 2'b10;
    push(S_DEV, 3); push(S_OCI, 3); drain();

    tag_cur = "invalid";
    SAIDA = 2'b11; PRODUTO = 2'b10;
    push(S_DEV, 3); push(S_OCI, 2); drain();

    tag_cur = "milk_rst";
    SAIDA = 2'b00;
    push(S_OCI, 1); drain();
    SAIDA = 2'b11; PRODUTO = 2'b01;
    push(S_COP, 2); push(S_CAF, 4); push(S_LEI, 1); drain();
    #2;
    RESET = 1'b1;
    #1;
    chk("async_reset", obs_word(), exp_word(S_OCI));
    @(posedge CLK); #1;
    chk("held_reset", obs_word(), exp_word(S_OCI));
    RESET = 1'b0;

    tag_cur = "after_rst";
    push(S_COP, 2); push(S_CAF, 4); push(S_LEI, 3); push(S_WAI, 1); drain();

    tag_cur = "wait_toggle";
    SAIDA = 2'b10;
    push(S_WAI, 1); drain();
    SAIDA = 2'b11;
    push(S_WAI, 2); drain();
    RETIRADA = 1'b1;
    push(S_OCI, 1); drain();
    RETIRADA = 1'b0;
    push(S_OCI, 2); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
